reg_cmd_ctrl: RTL and testbench



---
 rtl/reg_cmd_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_reg_cmd_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_ctrl.sv
// rtl/reg_cmd_ctrl.sv - command-frame decoder and register-file master
//
// Parses byte frames from the UART RX path and drives the register file:
//   write frame: 0xAA, addr, data  -> one WrEn strobe with Address/WrData
//   read frame : 0xBB, addr        -> one RdEn strobe, waits for RdData_VLD,
//                                     then pushes the read byte to the TX FIFO
// Malformed bytes, bad addresses and read timeouts raise a one-cycle CMD_ERR.
//
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   RX_P_DATA, RX_D_VLD   received byte and its one-cycle valid pulse
//   RdData, RdData_VLD    read data returned by the register file
//   FIFO_FULL             TX FIFO back-pressure
//   WrEn, RdEn            one-cycle register-file strobes
//   Address, WrData       register-file address / write data (held)
//   TX_P_DATA, TX_D_VLD   byte pushed to the TX FIFO and its push pulse
//   CMD_ERR               one-cycle error pulse
//
// Optional feature macro: REG_CMD_WR_ACK_EN
//   When defined, every completed write is acknowledged by pushing 0x5A to
//   the TX FIFO from an extra WR_ACK state.

module reg_cmd_ctrl #(
    parameter int WIDTH      = 8,
    parameter int ADDR       = 4,
    parameter int RD_TIMEOUT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] RX_P_DATA,
    input  logic             RX_D_VLD,
    input  logic [WIDTH-1:0] RdData,
    input  logic             RdData_VLD,
    input  logic             FIFO_FULL,
    output logic             WrEn,
    output logic             RdEn,
    output logic [ADDR-1:0]  Address,
    output logic [WIDTH-1:0] WrData,
    output logic [WIDTH-1:0] TX_P_DATA,
    output logic             TX_D_VLD,
    output logic             CMD_ERR
);

    localparam logic [WIDTH-1:0] OP_WR   = WIDTH'(8'hAA);
    localparam logic [WIDTH-1:0] OP_RD   = WIDTH'(8'hBB);
    localparam int               CNT_W   = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_TIMEOUT);
`ifdef REG_CMD_WR_ACK_EN
    localparam logic [WIDTH-1:0] ACK_BYTE = WIDTH'(8'h5A);
`endif

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        RD_SEND
`ifdef REG_CMD_WR_ACK_EN
        ,
        WR_ACK
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [ADDR-1:0]  wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en_q, wr_en_d;
    logic             rd_en_q, rd_en_d;
    logic [ADDR-1:0]  address_q, address_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             tx_vld_q, tx_vld_d;
    logic             err_q, err_d;
    logic             addr_ok;

    // An address byte is legal only if nothing is set above the ADDR field.
    assign addr_ok = (RX_P_DATA[WIDTH-1:ADDR] == '0);

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        rd_data_d = rd_data_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        tx_vld_d  = 1'b0;
        err_d     = 1'b0;
        address_d = address_q;
        wr_data_d = wr_data_q;
        tx_data_d = tx_data_q;

        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == OP_WR)      state_d = WR_ADDR;
                    else if (RX_P_DATA == OP_RD) state_d = RD_ADDR;
                    else                         err_d   = 1'b1;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    if (addr_ok) begin
                        wr_addr_d = RX_P_DATA[ADDR-1:0];
                        state_d   = WR_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    address_d = wr_addr_q;
                    wr_data_d = RX_P_DATA;
`ifdef REG_CMD_WR_ACK_EN
                    state_d   = WR_ACK;
`else
                    state_d   = IDLE;
`endif
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (addr_ok) begin
                        rd_en_d   = 1'b1;
                        address_d = RX_P_DATA[ADDR-1:0];
                        cnt_d     = '0;
                        state_d   = RD_WAIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            RD_WAIT: begin
                // cnt_q counts cycles since the RdEn cycle; data is still
                // accepted in the cycle where cnt_q reaches RD_TIMEOUT.
                if (RdData_VLD) begin
                    rd_data_d = RdData;
                    state_d   = RD_SEND;
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (RX_D_VLD) err_d = 1'b1;
            end
            RD_SEND: begin
                if (!FIFO_FULL) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = rd_data_q;
                    state_d   = IDLE;
                end
                if (RX_D_VLD) err_d = 1'b1;
            end
`ifdef REG_CMD_WR_ACK_EN
            WR_ACK: begin
                if (!FIFO_FULL) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = ACK_BYTE;
                    state_d   = IDLE;
                end
                if (RX_D_VLD) err_d = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
            rd_data_q <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            address_q <= '0;
            wr_data_q <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            rd_data_q <= rd_data_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            address_q <= address_d;
            wr_data_q <= wr_data_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            err_q     <= err_d;
        end
    end

    assign WrEn      = wr_en_q;
    assign RdEn      = rd_en_q;
    assign Address   = address_q;
    assign WrData    = wr_data_q;
    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign CMD_ERR   = err_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb/tb_reg_cmd_ctrl.sv - self-checking bench for reg_cmd_ctrl

module tb_reg_cmd_ctrl;

    localparam int TO = 4;
`ifdef REG_CMD_WR_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD = 1'b0;
    logic [7:0] RdData = '0;
    logic       RdData_VLD = 1'b0;
    logic       FIFO_FULL = 1'b0;
    logic       WrEn, RdEn, TX_D_VLD, CMD_ERR;
    logic [3:0] Address;
    logic [7:0] WrData, TX_P_DATA;

    reg_cmd_ctrl #(.WIDTH(8), .ADDR(4), .RD_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_VLD(RdData_VLD), .FIFO_FULL(FIFO_FULL),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        step();
        RX_D_VLD  = 1'b0;
    endtask

    // Event log: 0 = write, 1 = read strobe, 2 = TX push, 3 = error
    typedef struct packed {
        logic [1:0] k;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0, overlap = 0;
    logic [7:0] last_wa = '0, last_wd = '0, last_ra = '0, last_tx = '0;

    always @(negedge CLK) begin
        if (!RST) begin
            if (WrEn) begin
                n_wr++; last_wa = {4'h0, Address}; last_wd = WrData;
                obs_q.push_back('{2'd0, {4'h0, Address}, WrData});
            end
            if (RdEn) begin
                n_rd++; last_ra = {4'h0, Address};
                obs_q.push_back('{2'd1, {4'h0, Address}, 8'h00});
            end
            if (TX_D_VLD) begin
                n_tx++; last_tx = TX_P_DATA;
                obs_q.push_back('{2'd2, 8'h00, TX_P_DATA});
            end
            if (CMD_ERR) begin
                n_err++;
                obs_q.push_back('{2'd3, 8'h00, 8'h00});
            end
            if (WrEn && RdEn) overlap++;
        end
    end

    // Register-file responder: answers RdEn after rd_delay cycles (0 = never).
    logic [7:0] regs[16];
    logic [7:0] mem_m[16];
    int         rd_delay = 1;
    int         pend = 0;
    logic [3:0] pend_a = '0;

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            RdData_VLD = 1'b0;
            if (RST) pend = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    RdData_VLD = 1'b1;
                    RdData     = regs[pend_a];
                end
            end
            if (!RST && WrEn) regs[Address] = WrData;
            if (!RST && RdEn && rd_delay > 0) begin
                pend   = rd_delay;
                pend_a = Address;
            end
        end
    end

    task automatic compare_q(input string name);
        check({name, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check({name, "_event"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         nb, rdly;
        int         wr, rd, tx, err;
        logic [7:0] a, d;
    } vec_t;

    vec_t vt[13];

    initial begin
        int w0, r0, t0, e0;
        int kind;
        logic [7:0] a, d, op;

        vt[0]  = '{8'hAA, 8'h05, 8'h3C, 3, 1, 1, 0, 0, 0, 8'h05, 8'h3C};
        vt[1]  = '{8'hBB, 8'h02, 8'h00, 2, 1, 0, 1, 1, 0, 8'h02, 8'h81};
        vt[2]  = '{8'h11, 8'h00, 8'h00, 1, 1, 0, 0, 0, 1, 8'h00, 8'h00};
        vt[3]  = '{8'hAA, 8'h25, 8'h00, 2, 1, 0, 0, 0, 1, 8'h00, 8'h00};
        vt[4]  = '{8'hBB, 8'h05, 8'h00, 2, 1, 0, 1, 1, 0, 8'h05, 8'h3C};
        vt[5]  = '{8'hBB, 8'hF0, 8'h00, 2, 1, 0, 0, 0, 1, 8'h00, 8'h00};
        vt[6]  = '{8'hAA, 8'h0F, 8'hFF, 3, 1, 1, 0, 0, 0, 8'h0F, 8'hFF};
        vt[7]  = '{8'hBB, 8'h0F, 8'h00, 2, 2, 0, 1, 1, 0, 8'h0F, 8'hFF};
        vt[8]  = '{8'hBB, 8'h0E, 8'h00, 2, 0, 0, 1, 0, 1, 8'h0E, 8'h00};
        vt[9]  = '{8'hAA, 8'h10, 8'h00, 2, 1, 0, 0, 0, 1, 8'h00, 8'h00};
        vt[10] = '{8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 0, 1, 8'h00, 8'h00};
        vt[11] = '{8'hBB, 8'h02, 8'h00, 2, TO, 0, 1, 1, 0, 8'h02, 8'h81};
        vt[12] = '{8'hBB, 8'h02, 8'h00, 2, TO + 1, 0, 1, 0, 1, 8'h02, 8'h00};

        for (int i = 0; i < 16; i++) begin
            regs[i]  = 8'(i * 19 + 7);
            mem_m[i] = 8'(i * 19 + 7);
        end
        regs[2]  = 8'h81;
        mem_m[2] = 8'h81;

        // Reset state
        repeat (3) step();
        check("rst_wren", WrEn, 0);
        check("rst_rden", RdEn, 0);
        check("rst_addr", Address, 0);
        check("rst_wrdata", WrData, 0);
        check("rst_txdata", TX_P_DATA, 0);
        check("rst_txvld", TX_D_VLD, 0);
        check("rst_cmderr", CMD_ERR, 0);
        RST = 1'b0;
        step();

        // Table of single frames
        for (int i = 0; i < 13; i++) begin
            w0 = n_wr; r0 = n_rd; t0 = n_tx; e0 = n_err;
            rd_delay = vt[i].rdly;
            send(vt[i].b0);
            if (vt[i].nb > 1) send(vt[i].b1);
            if (vt[i].nb > 2) send(vt[i].b2);
            repeat (TO + 8) step();
            check($sformatf("vec%0d_wr", i), n_wr - w0, vt[i].wr);
            check($sformatf("vec%0d_rd", i), n_rd - r0, vt[i].rd);
            check($sformatf("vec%0d_tx", i), n_tx - t0, vt[i].tx + ((ACK && vt[i].wr != 0) ? 1 : 0));
            check($sformatf("vec%0d_err", i), n_err - e0, vt[i].err);
            if (vt[i].wr != 0) begin
                check($sformatf("vec%0d_waddr", i), last_wa, vt[i].a);
                check($sformatf("vec%0d_wdata", i), last_wd, vt[i].d);
                mem_m[vt[i].a[3:0]] = vt[i].d;
            end
            if (vt[i].rd != 0) check($sformatf("vec%0d_raddr", i), last_ra, vt[i].a);
            if (vt[i].tx != 0) check($sformatf("vec%0d_txdata", i), last_tx, vt[i].d);
        end
        rd_delay = 1;

        // Back-pressure: push is held while FIFO_FULL, released one cycle later
        t0 = n_tx;
        FIFO_FULL = 1'b1;
        send(8'hBB);
        send(8'h02);
        repeat (10) step();
        check("bp_no_push", n_tx - t0, 0);
        FIFO_FULL = 1'b0;
        step();
        check("bp_push_vld", TX_D_VLD, 1);
        check("bp_push_data", TX_P_DATA, 8'h81);
        step();
        check("bp_push_once", TX_D_VLD, 0);
        repeat (4) step();

        // Read timeout: CMD_ERR appears RD_TIMEOUT+1 cycles after the RdEn cycle
        rd_delay = 0;
        e0 = n_err;
        send(8'hBB);
        send(8'h06);
        check("to_rden", RdEn, 1);
        repeat (TO) step();
        check("to_not_early", n_err - e0 + CMD_ERR, 0);
        step();
        check("to_err", CMD_ERR, 1);
        step();
        check("to_err_pulse", CMD_ERR, 0);
        rd_delay = 1;
        repeat (4) step();
        obs_q.delete();

        // Streaming: write then read of the same register, bytes back to back
        send(8'hAA); send(8'h01); send(8'h11);
        if (ACK) step();
        send(8'hBB); send(8'h01);
        repeat (TO + 6) step();
        exp_q.push_back('{2'd0, 8'h01, 8'h11});
        if (ACK) exp_q.push_back('{2'd2, 8'h00, 8'h5A});
        exp_q.push_back('{2'd1, 8'h01, 8'h00});
        exp_q.push_back('{2'd2, 8'h00, 8'h11});
        compare_q("stream");
        mem_m[1] = 8'h11;

        // Reset mid-frame
        w0 = n_wr; e0 = n_err;
        send(8'hAA);
        send(8'h07);
        RST = 1'b1;
        #1;
        check("mid_rst_wren", WrEn, 0);
        check("mid_rst_addr", Address, 0);
        check("mid_rst_wrdata", WrData, 0);
        check("mid_rst_txdata", TX_P_DATA, 0);
        step();
        step();
        RST = 1'b0;
        step();
        send(8'h99);
        repeat (4) step();
        check("mid_rst_no_write", n_wr - w0, 0);
        check("mid_rst_err", n_err - e0, 1);
        obs_q.delete();

        // Randomized frames against the frame-level model
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    a = 8'($urandom_range(0, 15));
                    d = 8'($urandom);
                    FIFO_FULL = 1'($urandom_range(0, 1));
                    send(8'hAA); send(a); send(d);
                    exp_q.push_back('{2'd0, a, d});
                    if (ACK) exp_q.push_back('{2'd2, 8'h00, 8'h5A});
                    mem_m[a[3:0]] = d;
                end
                1: begin
                    op = ($urandom_range(0, 1) != 0) ? 8'hAA : 8'hBB;
                    a  = 8'($urandom_range(16, 255));
                    send(op); send(a);
                    exp_q.push_back('{2'd3, 8'h00, 8'h00});
                end
                2: begin
                    a = 8'($urandom_range(0, 15));
                    rd_delay = $urandom_range(1, TO);
                    FIFO_FULL = 1'($urandom_range(0, 1));
                    send(8'hBB); send(a);
                    exp_q.push_back('{2'd1, a, 8'h00});
                    exp_q.push_back('{2'd2, 8'h00, mem_m[a[3:0]]});
                end
                default: begin
                    op = 8'($urandom);
                    if (op == 8'hAA || op == 8'hBB) op = 8'h42;
                    send(op);
                    exp_q.push_back('{2'd3, 8'h00, 8'h00});
                end
            endcase
            repeat ($urandom_range(0, 6)) step();
            FIFO_FULL = 1'b0;
            repeat (TO + 6) step();
            compare_q($sformatf("rand%0d", f));
        end

        check("wr_rd_overlap", overlap, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
